// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared cell geometry, text-buffer word layout, palette and pipeline stage types
package vga_text_pkg;
  localparam int CHAR_W = 16;
  localparam int CHAR_H = 16;
  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] chr;
  } tb_word_t;
  localparam logic [11:0] PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };
  typedef struct packed {
    logic [3:0] px;
    logic [3:0] py;
    logic [5:0] col;
    logic [5:0] row;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       pix_en;
  } s1_t;
  typedef struct packed {
    logic [3:0] px;
    logic [3:0] py;
    logic [3:0] fg;
    logic [3:0] bg;
    logic       cursor_hit;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       pix_en;
  } s2_t;
  localparam s1_t S1_RST = '{px: 4'd0, py: 4'd0, col: 6'd0, row: 6'd0,
                             video_on: 1'b0, hsync: 1'b1, vsync: 1'b1, pix_en: 1'b0};
  localparam s2_t S2_RST = '{px: 4'd0, py: 4'd0, fg: 4'd0, bg: 4'd0, cursor_hit: 1'b0,
                             video_on: 1'b0, hsync: 1'b1, vsync: 1'b1, pix_en: 1'b0};
endpackage

// File: rtl/vga_text_renderer_if.sv
// vga_text_renderer_if: timing inputs, cursor, text/font memory ports and pixel outputs of the renderer
interface vga_text_renderer_if;
  logic         pix_en;
  logic [9:0]   pixel_x;
  logic [9:0]   pixel_y;
  logic         video_on;
  logic         hsync;
  logic         vsync;
  logic         cursor_en;
  logic [5:0]   cursor_col;
  logic [4:0]   cursor_row;
  logic [10:0]  tb_addr;
  logic [15:0]  tb_data;
  logic [7:0]   font_addr;
  logic [255:0] font_data;
  logic [11:0]  rgb_o;
  logic         hsync_o;
  logic         vsync_o;
  logic         pix_valid_o;
  modport master (
    output pix_en, pixel_x, pixel_y, video_on, hsync, vsync,
    output cursor_en, cursor_col, cursor_row, tb_data, font_data,
    input  tb_addr, font_addr, rgb_o, hsync_o, vsync_o, pix_valid_o
  );
  modport slave (
    input  pix_en, pixel_x, pixel_y, video_on, hsync, vsync,
    input  cursor_en, cursor_col, cursor_row, tb_data, font_data,
    output tb_addr, font_addr, rgb_o, hsync_o, vsync_o, pix_valid_o
  );
endinterface

// File: rtl/vga_cursor_blink.sv
// vga_cursor_blink: counts vsync falling edges and toggles the cursor phase every BLINK_FRAMES frames
module vga_cursor_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic blink_phase
);
  logic       prev_vs;
  logic       wrap;
  logic [7:0] frame_cnt;
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_range_check
    $error("BLINK_FRAMES must lie in 1..255");
  end
  assign wrap = frame_cnt == 8'(BLINK_FRAMES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vs     <= 1'b1;
      frame_cnt   <= 8'd0;
      blink_phase <= 1'b1;
    end else begin
      prev_vs <= vsync;
      if (prev_vs && !vsync) begin
        frame_cnt   <= wrap ? 8'd0 : frame_cnt + 8'd1;
        blink_phase <= wrap ? ~blink_phase : blink_phase;
      end
    end
  end
endmodule

// File: rtl/vga_text_renderer.sv
// vga_text_renderer: three-stage text-mode pipeline (cell fetch, glyph fetch, colour/cursor/sync realign)
module vga_text_renderer
  import vga_text_pkg::*;
#(
  parameter int TEXT_COLS    = 40,
  parameter int TEXT_ROWS    = 30,
  parameter int BLINK_FRAMES = 30
) (
  input logic                clk,
  input logic                rst,
  vga_text_renderer_if.slave bus
);
  s1_t        s1;
  s2_t        s2;
  tb_word_t   w;
  logic [5:0] col;
  logic [5:0] row;
  logic       blink_phase;
  logic       glyph_bit;
  logic [3:0] idx;
  if (TEXT_COLS * TEXT_ROWS > 2048) begin : g_geom_check
    $error("text grid does not fit the 11-bit text buffer address");
  end
  vga_cursor_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (clk),
    .rst         (rst),
    .vsync       (bus.vsync),
    .blink_phase (blink_phase)
  );
  always_comb begin
    col       = 6'(bus.pixel_x / 10'(CHAR_W));
    row       = 6'(bus.pixel_y / 10'(CHAR_H));
    w         = bus.tb_data;
    glyph_bit = bus.font_data[{s2.py, ~s2.px}];
    idx       = (glyph_bit ^ s2.cursor_hit) ? s2.fg : s2.bg;
  end
  // Out-of-grid addresses are left unchecked; such pixels are outside video_on
  assign bus.tb_addr   = 11'(int'(row) * TEXT_COLS + int'(col));
  assign bus.font_addr = w.chr;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1              <= S1_RST;
      s2              <= S2_RST;
      bus.rgb_o       <= 12'h000;
      bus.hsync_o     <= 1'b1;
      bus.vsync_o     <= 1'b1;
      bus.pix_valid_o <= 1'b0;
    end else begin
      s1 <= '{px: bus.pixel_x[3:0], py: bus.pixel_y[3:0], col: col, row: row,
              video_on: bus.video_on, hsync: bus.hsync, vsync: bus.vsync, pix_en: bus.pix_en};
      s2 <= '{px: s1.px, py: s1.py, fg: w.fg, bg: w.bg,
              cursor_hit: bus.cursor_en && s1.col == bus.cursor_col &&
                          s1.row == {1'b0, bus.cursor_row} && blink_phase,
              video_on: s1.video_on, hsync: s1.hsync, vsync: s1.vsync, pix_en: s1.pix_en};
      bus.rgb_o       <= s2.video_on ? PALETTE[idx] : 12'h000;
      bus.hsync_o     <= s2.hsync;
      bus.vsync_o     <= s2.vsync;
      bus.pix_valid_o <= s2.pix_en;
    end
  end
endmodule

// File: tb/tb_vga_text_renderer.sv
// tb_vga_text_renderer: directed and random pixels checked against a per-pixel behavioural model
module tb_vga_text_renderer;
  localparam int BF = 2;
  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        pv;
  } exp_t;
  localparam exp_t RST_EXP = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, pv: 1'b0};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int ncmp = 0;
  int nfail = 0;
  int falls = 0;
  logic pv_model = 1'b1;
  exp_t e [3];
  logic [15:0]  tbuf [2048];
  logic [255:0] font [256];
  logic [11:0]  pal [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };
  vga_text_renderer_if bus ();
  vga_text_renderer #(.BLINK_FRAMES(BF)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bus.tb_data   <= tbuf[bus.tb_addr];
    bus.font_data <= font[bus.font_addr];
  end
  function automatic exp_t model();
    int x = int'(bus.pixel_x);
    int y = int'(bus.pixel_y);
    logic [15:0] wd = tbuf[((y / 16) * 40 + x / 16) % 2048];
    logic [255:0] g = font[wd[7:0]];
    logic b = g[16 * (y % 16) + 15 - (x % 16)];
    logic ph = ((falls / BF) % 2) == 0;
    logic hit = bus.cursor_en && (x / 16 == int'(bus.cursor_col)) && (y / 16 == int'(bus.cursor_row)) && ph;
    logic [3:0] fg = wd[11:8];
    logic [3:0] bg = wd[15:12];
    logic [3:0] ci = hit ? (b ? bg : fg) : (b ? fg : bg);
    return '{rgb: bus.video_on ? pal[ci] : 12'h000, hs: bus.hsync, vs: bus.vsync, pv: bus.pix_en};
  endfunction
  task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      falls = 0;
      pv_model = 1'b1;
      e = '{RST_EXP, RST_EXP, RST_EXP};
    end else begin
      if (pv_model && !bus.vsync) falls++;
      pv_model = bus.vsync;
      e[2] = e[1];
      e[1] = e[0];
      e[0] = model();
    end
    #1;
    chk("rgb_o", bus.rgb_o, e[2].rgb);
    chk("hsync_o", 12'(bus.hsync_o), 12'(e[2].hs));
    chk("vsync_o", 12'(bus.vsync_o), 12'(e[2].vs));
    chk("pix_valid_o", 12'(bus.pix_valid_o), 12'(e[2].pv));
  endtask
  task automatic step(int x, int y, logic von, logic pe, logic hs, logic vs);
    bus.pixel_x  = 10'(x);
    bus.pixel_y  = 10'(y);
    bus.video_on = von;
    bus.pix_en   = pe;
    bus.hsync    = hs;
    bus.vsync    = vs;
    #1;
    chk("tb_addr", 12'(bus.tb_addr), 12'(((y / 16) * 40 + x / 16) % 2048));
    tick();
  endtask
  task automatic idle(int n);
    repeat (n) step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask
  task automatic vfall();
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask
  task automatic set_cursor(logic en, int c, int r);
    idle(1);
    bus.cursor_en  = en;
    bus.cursor_col = 6'(c);
    bus.cursor_row = 5'(r);
  endtask
  task automatic sweep_cell(int c, int r, int n);
    repeat (n) step(c * 16 + int'($urandom_range(0, 15)), r * 16 + int'($urandom_range(0, 15)),
                    1'b1, 1'b1, 1'b1, 1'b1);
  endtask
  initial begin
    int c, r, x, y;
    for (int i = 0; i < 2048; i++) tbuf[i] = 16'($urandom);
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 8; j++) font[i][32 * j +: 32] = $urandom;
    bus.cursor_en = 1'b0;
    bus.cursor_col = 6'd0;
    bus.cursor_row = 5'd0;
    repeat (3) step(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset rgb_o", bus.rgb_o, 12'h000);
    chk("reset vsync_o", 12'(bus.vsync_o), 12'h001);
    tbuf[0] = 16'h0F41;
    font[8'h41] = '1;
    rst = 1'b0;
    repeat (3) step(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("latency rgb_o", bus.rgb_o, 12'hFFF);
    chk("latency pix_valid_o", 12'(bus.pix_valid_o), 12'h001);
    bus.pixel_x = 10'd639;
    bus.pixel_y = 10'd479;
    #1 chk("tb_addr 639,479", 12'(bus.tb_addr), 12'd1199);
    bus.pixel_x = 10'd16;
    bus.pixel_y = 10'd16;
    #1 chk("tb_addr 16,16", 12'(bus.tb_addr), 12'd41);
    step(639, 479, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);
    tbuf[0] = 16'h0107;
    font[7] = '0;
    font[7][16 * 5 + 12] = 1'b1;
    for (int i = 0; i < 16; i++) step(i, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);
    for (int i = 0; i < 16; i++)
      step(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("blink_phase after reset", 12'(dut.u_blink.blink_phase), 12'h001);
    set_cursor(1'b1, 2, 1);
    sweep_cell(2, 1, 20);
    sweep_cell(1, 1, 6);
    sweep_cell(3, 1, 6);
    sweep_cell(2, 0, 6);
    repeat (2) vfall();
    chk("blink_phase after 2 falls", 12'(dut.u_blink.blink_phase), 12'h000);
    sweep_cell(2, 1, 20);
    repeat (2) vfall();
    chk("blink_phase after 4 falls", 12'(dut.u_blink.blink_phase), 12'h001);
    sweep_cell(2, 1, 20);
    set_cursor(1'b0, 2, 1);
    sweep_cell(2, 1, 10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    repeat (3) vfall();
    chk("frame_cnt before reset", 12'(dut.u_blink.frame_cnt), 12'd1);
    chk("blink_phase before reset", 12'(dut.u_blink.blink_phase), 12'h000);
    rst = 1'b1;
    step(40, 20, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("frame_cnt in reset", 12'(dut.u_blink.frame_cnt), 12'd0);
    chk("blink_phase in reset", 12'(dut.u_blink.blink_phase), 12'h001);
    rst = 1'b0;
    repeat (3) step(40, 20, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("first valid after reset", 12'(bus.pix_valid_o), 12'h001);
    for (int s = 0; s < 4; s++) begin
      c = int'($urandom_range(0, 39));
      r = int'($urandom_range(0, 29));
      set_cursor(1'($urandom_range(0, 3) != 0), c, r);
      for (int i = 0; i < 100; i++) begin
        x = $urandom_range(0, 1) != 0 ? c * 16 + int'($urandom_range(0, 15)) : int'($urandom_range(0, 639));
        y = $urandom_range(0, 1) != 0 ? r * 16 + int'($urandom_range(0, 15)) : int'($urandom_range(0, 479));
        step(x, y, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) != 0));
      end
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
